fetch_queue: RTL and testbench

Parametrised decoupling buffer between the fetch and decode stages of the pipelined core, replacing the single-entry IF/ID register with a DEPTH-entry ring buffer. Fetch pushes {instruction, PC} pairs; decode pops them under a valid/ready handshake, where pop_ready is the inverse of the decode stall. A flush from the hazard unit discards every buffered entry on a taken branch or jump. PCPlus4D is derived at the output, so the buffer stores only instruction and PC.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/fetch_queue_mem.sv | 26 ++
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch/decode entry bundle and the canonical NOP.
package pipeline_pkg;

    localparam int unsigned PKG_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [PKG_XLEN-1:0] inst;
        logic [PKG_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  fetch_entry_t  wdata,
    input  logic [PW-1:0] raddr,
    output fetch_entry_t  rdata
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode ring buffer with flush; optional same-cycle bypass
// when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [XLEN-1:0]              instF,
    input  logic [XLEN-1:0]              PCF,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output logic [XLEN-1:0]              instD,
    output logic [XLEN-1:0]              PCD,
    output logic [XLEN-1:0]              PCPlus4D,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    fetch_entry_t wr_entry;
    fetch_entry_t rd_entry;

    logic not_empty;
    logic bypass;
    logic push_fire;
    logic wr_en;
    logic rd_en;

    assign not_empty  = (count_q != '0);
    assign push_ready = (count_q != CW'(DEPTH));
    assign push_fire  = push_valid && push_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = !not_empty && push_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign pop_valid = not_empty || bypass;

    // A bypassed entry taken by decode this cycle never touches storage
    assign wr_en = push_fire && !flush && !(bypass && pop_ready);
    assign rd_en = not_empty && pop_ready && !flush;

    assign wr_entry.inst = instF;
    assign wr_entry.pc   = PCF;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_entry)
    );

    always_comb begin
        instD = NOP_INSTR;
        PCD   = '0;
        if (not_empty) begin
            instD = rd_entry.inst;
            PCD   = rd_entry.pc;
        end else if (bypass) begin
            instD = instF;
            PCD   = PCF;
        end
    end

    assign PCPlus4D = PCD + XLEN'(4);
    assign count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) tail_d = tail_q + PW'(1);
            if (rd_en) head_d = head_q + PW'(1);
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (both FETCH_QUEUE_BYPASS_EN builds).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] instF;
    logic [31:0] PCF;
    logic        pop_valid;
    logic        pop_ready;
    logic [31:0] instD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        flush;
    logic [2:0]  count;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_queue #(
        .XLEN  (32),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .instF      (instF),
        .PCF        (PCF),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .instD      (instD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5000033;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and checks happen 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc,
                         input logic pr, input logic fl);
        push_valid = pv;
        PCF        = pc;
        instF      = inst_of(pc);
        pop_ready  = pr;
        flush      = fl;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".push_ready"}, 32'(push_ready), 32'd1);
        chk({tag, ".pop_valid"},  32'(pop_valid),  32'd0);
        chk({tag, ".count"},      32'(count),      32'd0);
        chk({tag, ".instD"},      instD,           NOP);
        chk({tag, ".PCD"},        PCD,             32'd0);
        chk({tag, ".PCPlus4D"},   PCPlus4D,        32'd4);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk_reset_outs("rst");
        tick();
        tick();
        reset = 1'b0;

        // Fill with pop_ready low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            tick();
            chk($sformatf("fill.count%0d", i), 32'(count), 32'(i + 1));
        end
        chk("full.push_ready", 32'(push_ready), 32'd0);
        chk("full.pop_valid", 32'(pop_valid), 32'd1);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        chk("refuse.count", 32'(count), 32'd4);
        chk("refuse.PCD", PCD, 32'h0);

        // Drain in order
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain.PCD%0d", i), PCD, 32'(i * 4));
            chk($sformatf("drain.P4_%0d", i), PCPlus4D, 32'(i * 4 + 4));
            chk($sformatf("drain.inst%0d", i), instD, inst_of(32'(i * 4)));
            tick();
        end
        chk("drain.pop_valid", 32'(pop_valid), 32'd0);
        chk("drain.instD", instD, NOP);
        chk("drain.count", 32'(count), 32'd0);

        // Streaming push+pop across pointer wrap
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        chk("stream.prime", 32'(count), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(32'h204 + i * 4), 1'b1, 1'b0);
            chk($sformatf("stream.PCD%0d", i), PCD, 32'(32'h200 + i * 4));
            tick();
            chk($sformatf("stream.cnt%0d", i), 32'(count), 32'd1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream.last", PCD, 32'h228);
        tick();
        chk("stream.empty", 32'(count), 32'd0);

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h30 + i * 4), 1'b0, 1'b0);
            tick();
        end
        chk("flush.pre", 32'(count), 32'd3);
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        tick();
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.pop_valid", 32'(pop_valid), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush.PCD%0d", i), PCD, 32'h0);
            tick();
        end
        chk("flush.count_after", 32'(count), 32'd0);

        // PC wrap of PCPlus4D
        drive(1'b1, 32'hFFFFFFFC, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap.PCD", PCD, 32'hFFFFFFFC);
        chk("wrap.P4", PCPlus4D, 32'h00000000);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("wrap.empty", 32'(count), 32'd0);

        // Push into empty with decode ready
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp.PCD_same", PCD, 32'h100);
        chk("byp.valid_same", 32'(pop_valid), 32'd1);
        tick();
        chk("byp.count", 32'(count), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("byp.PCD_next", PCD, 32'h0);
`else
        chk("lat.PCD_same", PCD, 32'h0);
        chk("lat.valid_same", 32'(pop_valid), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lat.PCD_next", PCD, 32'h100);
        chk("lat.count", 32'(count), 32'd1);
        tick();
        chk("lat.drained", 32'(count), 32'd0);
`endif

        // Asynchronous reset mid-cycle with two entries queued
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'(32'h80 + i * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("arst.pre", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outs("arst");
        tick();
        reset = 1'b0;
        tick();
        chk("arst.hold", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
